// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// data width and the default bit period for 115200 baud at 100 MHz.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int UART_DATA_W        = 8;
  localparam int CLKS_PER_BIT_115K2 = 868;

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps by itself, so every
// bit boundary is also a reload point. restart holds the count at zero so the
// first bit of a frame begins with a full period.
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int              CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // Free-running period counter, held at zero while restart is high.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // tick marks the last cycle of the current bit period.
  assign tick = (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO and serialises each byte as an 8N1/8N2 UART frame,
// LSB first. The FIFO returns registered data one cycle after fifo_rd, which
// is why FETCH (pop) and LOAD (capture) are separate one-cycle states.
//
// Handshake: fifo_rd is a one-cycle pop strobe issued only from FETCH, and
// only after fifo_empty was seen low in IDLE; fifo_data is captured in the
// following LOAD cycle. This block is the FIFO's only reader, so the FIFO
// cannot go empty between the IDLE decision and the pop.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115K2,
  parameter int STOP_BITS    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   fifo_empty,
  input  logic [UART_DATA_W-1:0] fifo_data,
  output logic                   fifo_rd,
  output logic                   tx,
  output logic                   busy,
  output logic                   byte_done,
  output logic [15:0]            frames_sent,
  output tx_state_t              state_dbg
);

  tx_state_t              state;
  logic [UART_DATA_W-1:0] shift_reg;
  logic [2:0]             bit_idx;
  logic                   stop_idx;
  logic                   tick;
  logic                   restart;
  logic                   last_stop;

  // Timer is held in reset outside the serial states, so START always
  // begins with a fresh, full bit period.
  assign restart = (state == IDLE) || (state == FETCH) || (state == LOAD);

  tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;

  assign fifo_rd   = (state == FETCH);
  assign busy      = (state != IDLE);
  assign byte_done = (state == STOP) && tick && last_stop;
  assign state_dbg = state;

  // Frame sequencer: tx is registered and only updated on state entry or at
  // a bit boundary, so the line never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tx          <= 1'b1;
      shift_reg   <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      frames_sent <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (enable && !fifo_empty) begin
            state <= FETCH;
          end
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          shift_reg <= fifo_data;
          tx        <= 1'b0;
          state     <= START;
        end
        START: begin
          if (tick) begin
            tx      <= shift_reg[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'(UART_DATA_W - 1)) begin
              tx       <= 1'b1;
              stop_idx <= 1'b0;
              state    <= STOP;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              shift_reg <= {1'b0, shift_reg[UART_DATA_W-1:1]};
              tx        <= shift_reg[1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (last_stop) begin
              frames_sent <= frames_sent + 16'd1;
              state       <= IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (4 clk/bit 1 stop, 3 clk/bit 2 stop)
// each fed by a simple FIFO model with registered read data. Expected line
// levels are derived from the byte value and the frame format.
module tb_fifo_uart_tx;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst    = 1'b1;
  logic enable = 1'b0;

  // Instance A: CLKS_PER_BIT=4, STOP_BITS=1
  logic [7:0]  mem_a [0:255];
  logic [7:0]  wp_a   = 8'd0;
  logic [7:0]  rp_a   = 8'd0;
  logic [7:0]  data_a = 8'd0;
  logic        empty_a, rd_a, tx_a, busy_a, done_a;
  logic [15:0] fs_a;
  tx_state_t   st_a;

  // Instance B: CLKS_PER_BIT=3, STOP_BITS=2
  logic [7:0]  mem_b [0:255];
  logic [7:0]  wp_b   = 8'd0;
  logic [7:0]  rp_b   = 8'd0;
  logic [7:0]  data_b = 8'd0;
  logic        empty_b, rd_b, tx_b, busy_b, done_b;
  logic [15:0] fs_b;
  tx_state_t   st_b;

  assign empty_a = (wp_a == rp_a);
  assign empty_b = (wp_b == rp_b);

  // FIFO read ports: data registered one cycle after the pop.
  always @(posedge clk) begin
    if (rd_a) begin
      data_a <= mem_a[rp_a];
      rp_a   <= rp_a + 8'd1;
    end
    if (rd_b) begin
      data_b <= mem_b[rp_b];
      rp_b   <= rp_b + 8'd1;
    end
  end

  fifo_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .fifo_empty  (empty_a),
    .fifo_data   (data_a),
    .fifo_rd     (rd_a),
    .tx          (tx_a),
    .busy        (busy_a),
    .byte_done   (done_a),
    .frames_sent (fs_a),
    .state_dbg   (st_a)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(3), .STOP_BITS(2)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .fifo_empty  (empty_b),
    .fifo_data   (data_b),
    .fifo_rd     (rd_b),
    .tx          (tx_b),
    .busy        (busy_b),
    .byte_done   (done_b),
    .frames_sent (fs_b),
    .state_dbg   (st_b)
  );

  // Selected instance under test
  logic        sel = 1'b0;
  logic        rd_m, tx_m, busy_m, done_m;
  logic [15:0] fs_m;
  assign rd_m   = sel ? rd_b   : rd_a;
  assign tx_m   = sel ? tx_b   : tx_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign done_m = sel ? done_b : done_a;
  assign fs_m   = sel ? fs_b   : fs_a;

  int          vectors    = 0;
  int          miscompares = 0;
  logic [15:0] exp_frames = 16'd0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    if (!sel) begin
      mem_a[wp_a] = b;
      wp_a = wp_a + 8'd1;
    end else begin
      mem_b[wp_b] = b;
      wp_b = wp_b + 8'd1;
    end
  endtask

  // Wait (bounded) for the pop strobe; returns the number of cycles waited.
  task automatic wait_pop(output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!rd_m && waited < 60);
    check("pop_seen", 16'(rd_m), 16'd1);
  endtask

  // Called on the FETCH cycle. Checks LOAD, then every cycle of the frame.
  // drop_at / rst_at are frame-cycle indices (-1 = never).
  task automatic run_frame(input logic [7:0] b, input int drop_at, input int rst_at);
    int cpb;
    int stops;
    int n;
    int k;
    int lvl;
    cpb   = sel ? 3 : 4;
    stops = sel ? 2 : 1;
    n     = (9 + stops) * cpb;
    @(negedge clk);
    check("load_tx", 16'(tx_m), 16'd1);
    check("load_busy", 16'(busy_m), 16'd1);
    check("load_rd", 16'(rd_m), 16'd0);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_frames = 16'd0;
        check("rst_tx", 16'(tx_m), 16'd1);
        check("rst_busy", 16'(busy_m), 16'd0);
        check("rst_frames", fs_m, exp_frames);
        return;
      end
      k   = c / cpb;
      lvl = (k == 0) ? 0 : ((k <= 8) ? int'((b >> (k - 1)) & 8'd1) : 1);
      check("tx", 16'(tx_m), 16'(lvl));
      check("byte_done", 16'(done_m), 16'(c == n - 1));
      check("rd_in_frame", 16'(rd_m), 16'd0);
      if (c == drop_at) enable = 1'b0;
    end
    exp_frames = exp_frames + 16'd1;
    @(negedge clk);
    check("frames_sent", fs_m, exp_frames);
    check("idle_busy", 16'(busy_m), 16'd0);
    check("idle_tx", 16'(tx_m), 16'd1);
  endtask

  initial begin
    int w;
    logic [7:0] bytes [$];
    logic [7:0] rb;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_a", 16'(tx_a), 16'd1);
    check("rst_rd_a", 16'(rd_a), 16'd0);
    check("rst_busy_a", 16'(busy_a), 16'd0);
    check("rst_done_a", 16'(done_a), 16'd0);
    check("rst_fs_a", fs_a, 16'd0);
    check("rst_state_a", {13'd0, st_a}, {13'd0, IDLE});
    check("rst_tx_b", 16'(tx_b), 16'd1);
    check("rst_state_b", {13'd0, st_b}, {13'd0, IDLE});
    rst = 1'b0;
    @(negedge clk);

    // Single byte 0xA5
    enable = 1'b1;
    push(8'hA5);
    wait_pop(w);
    check("first_latency", 16'(w), 16'd1);
    run_frame(8'hA5, -1, -1);

    // Back-to-back: directed plus random bytes, fixed 3-cycle idle gap
    bytes = '{8'h00, 8'hFF, 8'h3C};
    repeat (4) begin
      rb = 8'($urandom_range(0, 255));
      bytes.push_back(rb);
    end
    foreach (bytes[i]) push(bytes[i]);
    foreach (bytes[i]) begin
      wait_pop(w);
      if (i != 0) check("b2b_gap", 16'(w), 16'd1);
      run_frame(bytes[i], -1, -1);
    end
    repeat (10) begin
      @(negedge clk);
      check("b2b_no_pop", 16'(rd_m), 16'd0);
    end

    // Empty FIFO: no pop, line idle
    repeat (100) begin
      @(negedge clk);
      check("empty_no_pop", 16'(rd_m), 16'd0);
      check("empty_tx", 16'(tx_m), 16'd1);
    end

    // Disabled with data present: no pop
    enable = 1'b0;
    push(8'h96);
    push(8'hC3);
    repeat (20) begin
      @(negedge clk);
      check("dis_no_pop", 16'(rd_m), 16'd0);
      check("dis_busy", 16'(busy_m), 16'd0);
    end

    // Enable dropped during DATA: frame completes, no further pop
    enable = 1'b1;
    wait_pop(w);
    run_frame(8'h96, 4 * 3 + 1, -1);
    repeat (30) begin
      @(negedge clk);
      check("drop_no_pop", 16'(rd_m), 16'd0);
    end
    enable = 1'b1;
    wait_pop(w);
    run_frame(8'hC3, -1, -1);

    // Reset during data bit 3 of 0x5A; next byte goes out intact
    push(8'h5A);
    push(8'h33);
    wait_pop(w);
    run_frame(8'h5A, -1, 4 * 4);
    wait_pop(w);
    check("post_rst_latency", 16'(w), 16'd1);
    run_frame(8'h33, -1, -1);

    // Counter wrap
    @(negedge clk);
    dut_a.frames_sent = 16'hFFFF;
    exp_frames = 16'hFFFF;
    rb = 8'($urandom_range(0, 255));
    push(rb);
    wait_pop(w);
    run_frame(rb, -1, -1);

    // Two stop bits, 3 clk/bit
    sel = 1'b1;
    exp_frames = 16'd0;
    push(8'h81);
    wait_pop(w);
    run_frame(8'h81, -1, -1);
    bytes.delete();
    repeat (3) begin
      rb = 8'($urandom_range(0, 255));
      bytes.push_back(rb);
    end
    foreach (bytes[i]) push(bytes[i]);
    foreach (bytes[i]) begin
      wait_pop(w);
      check("b2b_gap_b", 16'(w), 16'd1);
      run_frame(bytes[i], -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
